// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and the width of the op field.
package alu_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 2'b00,  // a + b
    OP_ADDC = 2'b01,  // a + b + cin
    OP_SUB  = 2'b10,  // a + ~b + 1
    OP_SUBC = 2'b11   // a + ~b + cin
  } alu_op_e;

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// Issue-side / result-side handshake bundle for cla_pipe_addsub.
//   in_*  : operands with valid/ready, driven by the issue stage (master)
//   out_* : result and flags with valid/ready, consumed by the result mux (master)
interface cla_pipe_addsub_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [OP_W-1:0]  in_op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_op, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_op, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

endinterface

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead group.
//   a_i, b_i : operand slices
//   cin_i    : carry into the group's LSB
//   sum_o    : sum slice
//   g_o, p_o : group generate / propagate, independent of cin_i
module cla_group #(
  parameter int unsigned GROUP = 8
) (
  input  logic [GROUP-1:0] a_i,
  input  logic [GROUP-1:0] b_i,
  input  logic             cin_i,
  output logic [GROUP-1:0] sum_o,
  output logic             g_o,
  output logic             p_o
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic             c;

  always_comb begin
    g     = a_i & b_i;
    p     = a_i ^ b_i;
    c     = cin_i;
    g_o   = 1'b0;
    sum_o = '0;
    for (int i = 0; i < int'(GROUP); i++) begin
      sum_o[i] = p[i] ^ c;
      c        = g[i] | (p[i] & c);
      g_o      = g[i] | (p[i] & g_o);
    end
    p_o = &p;
  end

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor with full valid/ready backpressure.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of cla_pipe_addsub_if (operands in, result + cout/ovf/zero out)
// Stage k resolves lookahead groups k*GPS .. k*GPS+GPS-1; the final stage also
// registers the flags alongside the full sum.
module cla_pipe_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned GROUP  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  cla_pipe_addsub_if.slave  bus
);

  localparam int unsigned NG   = WIDTH / GROUP;
  localparam int unsigned GPS  = NG / STAGES;
  localparam int unsigned SW   = GPS * GROUP;
  localparam int unsigned LAST = STAGES - 1;

  if (GROUP == 0 || (WIDTH % GROUP) != 0) begin : g_bad_group
    $error("cla_pipe_addsub: WIDTH must be a non-zero multiple of GROUP");
  end
  if (STAGES == 0 || (NG % STAGES) != 0) begin : g_bad_stages
    $error("cla_pipe_addsub: STAGES must divide WIDTH/GROUP");
  end

  // Pipeline state; index k is the register at the output of stage k.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic              ovf_q, zero_q;

  // Stage inputs (k=0 from the bus, otherwise from register k-1).
  logic [STAGES-1:0] v_s, c_s, en, c_d;
  logic [WIDTH-1:0]  a_s   [STAGES];
  logic [WIDTH-1:0]  b_s   [STAGES];
  logic [WIDTH-1:0]  s_s   [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic              c0, ovf_d, zero_d, cmsb;

  // Per-group signals across all stages.
  logic [WIDTH-1:0]  gs;
  logic [NG-1:0]     gg, gp, gc;

  // Input conditioning: subtract inverts B; carry-in chosen by op.
  always_comb begin
    unique case (bus.in_op)
      OP_ADD:  c0 = 1'b0;
      OP_SUB:  c0 = 1'b1;
      OP_ADDC: c0 = bus.in_cin;
      OP_SUBC: c0 = bus.in_cin;
      default: c0 = 1'b0;
    endcase
  end

  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      if (k == 0) begin
        v_s[k] = bus.in_valid;
        a_s[k] = bus.in_a;
        b_s[k] = bus.in_op[1] ? ~bus.in_b : bus.in_b;
        c_s[k] = c0;
        s_s[k] = '0;
      end else begin
        v_s[k] = v_q[k-1];
        a_s[k] = a_q[k-1];
        b_s[k] = b_q[k-1];
        c_s[k] = c_q[k-1];
        s_s[k] = sum_q[k-1];
      end
    end
  end

  for (genvar g = 0; g < int'(NG); g++) begin : g_grp
    cla_group #(
      .GROUP (GROUP)
    ) u_grp (
      .a_i   (a_s[g / GPS][g*GROUP +: GROUP]),
      .b_i   (b_s[g / GPS][g*GROUP +: GROUP]),
      .cin_i (gc[g]),
      .sum_o (gs[g*GROUP +: GROUP]),
      .g_o   (gg[g]),
      .p_o   (gp[g])
    );
  end

  // Two-level lookahead inside each stage: every group carry is a flat
  // sum-of-products of the stage carry-in and the G/P of lower groups.
  always_comb begin
    logic cj, t;
    gc  = '0;
    c_d = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      for (int j = 0; j <= int'(GPS); j++) begin
        cj = c_s[k];
        for (int i = 0; i < j; i++) cj = cj & gp[k*GPS + i];
        for (int i = 0; i < j; i++) begin
          t = gg[k*GPS + i];
          for (int m = i + 1; m < j; m++) t = t & gp[k*GPS + m];
          cj = cj | t;
        end
        if (j < int'(GPS)) gc[k*GPS + j] = cj;
        else               c_d[k]        = cj;
      end
    end
  end

  // Merge this stage's resolved slice into the running sum.
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      for (int b = 0; b < int'(WIDTH); b++) begin
        sum_d[k][b] = (b / int'(SW) == k) ? gs[b] : s_s[k][b];
      end
    end
    // Carry into the MSB recovered from the MSB sum bit.
    cmsb   = a_s[LAST][WIDTH-1] ^ b_s[LAST][WIDTH-1] ^ gs[WIDTH-1];
    ovf_d  = c_d[LAST] ^ cmsb;
    zero_d = ~|sum_d[LAST];
  end

  // Enable chain: a stage may load when empty or when its content moves on.
  always_comb begin
    en       = '0;
    en[LAST] = ~v_q[LAST] | bus.out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) en[k] = ~v_q[k] | en[k+1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (en[k]) begin
          v_q[k] <= v_s[k];
          // Bubbles only clear the valid bit; data is left as-is.
          if (v_s[k]) begin
            sum_q[k] <= sum_d[k];
            a_q[k]   <= a_s[k];
            b_q[k]   <= b_s[k];
            c_q[k]   <= c_d[k];
          end
        end
      end
      if (en[LAST] && v_s[LAST]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign bus.in_ready  = en[0];
  assign bus.out_valid = v_q[LAST];
  assign bus.out_sum   = sum_q[LAST];
  assign bus.out_cout  = c_q[LAST];
  assign bus.out_ovf   = ovf_q;
  assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: four instances (32/8/2, 16/4/2, 32/8/1, 32/8/4)
// checked against a plain-arithmetic model of add/sub with flags.
module tb_cla_pipe_addsub;
  import alu_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  cla_pipe_addsub_if #(.WIDTH(32)) bm ();
  cla_pipe_addsub_if #(.WIDTH(16)) br ();
  cla_pipe_addsub_if #(.WIDTH(32)) b1 ();
  cla_pipe_addsub_if #(.WIDTH(32)) b4 ();

  cla_pipe_addsub #(.WIDTH(32), .GROUP(8), .STAGES(2)) u_main (
    .clock(clock), .reset_n(reset_n), .bus(bm));
  cla_pipe_addsub #(.WIDTH(16), .GROUP(4), .STAGES(2)) u_r16 (
    .clock(clock), .reset_n(reset_n), .bus(br));
  cla_pipe_addsub #(.WIDTH(32), .GROUP(8), .STAGES(1)) u_s1 (
    .clock(clock), .reset_n(reset_n), .bus(b1));
  cla_pipe_addsub #(.WIDTH(32), .GROUP(8), .STAGES(4)) u_s4 (
    .clock(clock), .reset_n(reset_n), .bus(b4));

  int n_vec = 0;
  int n_err = 0;
  int stg_of [4] = '{2, 2, 1, 4};
  int w_of   [4] = '{32, 16, 32, 32};

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  // Reference: (w+1)-bit arithmetic; overflow from operand/result signs.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic [1:0] op);
    logic [63:0] mask, aa, bb, full;
    logic        c0;
    res_t        r;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'h0, a} & mask;
    bb   = op[1] ? (~{32'h0, b}) & mask : {32'h0, b} & mask;
    if (op == OP_ADD)      c0 = 1'b0;
    else if (op == OP_SUB) c0 = 1'b1;
    else                   c0 = cin;
    full   = aa + bb + {63'd0, c0};
    r.sum  = full[31:0] & mask[31:0];
    r.cout = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    r.zero = (r.sum == 32'h0);
    return r;
  endfunction

  task automatic drv(input int s, input logic v, input logic [31:0] a, input logic [31:0] b,
                     input logic cin, input logic [1:0] op, input logic ordy);
    case (s)
      0: begin bm.in_valid = v; bm.in_a = a; bm.in_b = b; bm.in_cin = cin;
               bm.in_op = op; bm.out_ready = ordy; end
      1: begin br.in_valid = v; br.in_a = a[15:0]; br.in_b = b[15:0]; br.in_cin = cin;
               br.in_op = op; br.out_ready = ordy; end
      2: begin b1.in_valid = v; b1.in_a = a; b1.in_b = b; b1.in_cin = cin;
               b1.in_op = op; b1.out_ready = ordy; end
      default: begin b4.in_valid = v; b4.in_a = a; b4.in_b = b; b4.in_cin = cin;
               b4.in_op = op; b4.out_ready = ordy; end
    endcase
  endtask

  task automatic smp(input int s, output logic irdy, output logic ov, output logic [31:0] sm,
                     output logic co, output logic of, output logic z);
    case (s)
      0: begin irdy = bm.in_ready; ov = bm.out_valid; sm = bm.out_sum;
               co = bm.out_cout; of = bm.out_ovf; z = bm.out_zero; end
      1: begin irdy = br.in_ready; ov = br.out_valid; sm = {16'h0, br.out_sum};
               co = br.out_cout; of = br.out_ovf; z = br.out_zero; end
      2: begin irdy = b1.in_ready; ov = b1.out_valid; sm = b1.out_sum;
               co = b1.out_cout; of = b1.out_ovf; z = b1.out_zero; end
      default: begin irdy = b4.in_ready; ov = b4.out_valid; sm = b4.out_sum;
               co = b4.out_cout; of = b4.out_ovf; z = b4.out_zero; end
    endcase
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(9))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_8000;
      default: return $urandom();
    endcase
  endfunction

  // One isolated op on an idle pipe: checks latency and the exact result.
  task automatic single_op(input int s, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic [1:0] op, input logic [31:0] e_sum,
                           input logic e_co, input logic e_of, input logic e_z,
                           input string name);
    logic irdy, ov, co, of, z;
    logic [31:0] sm;
    int cyc;
    @(negedge clock);
    drv(s, 1'b1, a, b, cin, op, 1'b1);
    #1 smp(s, irdy, ov, sm, co, of, z);
    n_vec++;
    if (irdy !== 1'b1) begin
      n_err++; $display("FAIL %s_in_ready: got %b want 1", name, irdy);
    end
    cyc = 0;
    ov  = 1'b0;
    while (ov !== 1'b1 && cyc < 12) begin
      @(posedge clock);
      #1;
      if (cyc == 0) drv(s, 1'b0, a, b, cin, op, 1'b1);
      cyc++;
      @(negedge clock);
      smp(s, irdy, ov, sm, co, of, z);
    end
    n_vec++;
    if (ov !== 1'b1 || cyc != stg_of[s]) begin
      n_err++; $display("FAIL %s_latency: got %0d cycles want %0d", name, cyc, stg_of[s]);
    end
    n_vec++;
    if (sm !== e_sum) begin
      n_err++; $display("FAIL %s_sum: got %h want %h", name, sm, e_sum);
    end
    n_vec++;
    if ({co, of, z} !== {e_co, e_of, e_z}) begin
      n_err++; $display("FAIL %s_flags: got cout/ovf/zero %b%b%b want %b%b%b",
                        name, co, of, z, e_co, e_of, e_z);
    end
  endtask

  // Streaming scoreboard. rmode 0: out_ready 1,0,0,1 pattern, input always offered;
  // rmode 1: random ready and random input gaps.
  task automatic run_stream(input int s, input int n_ops, input int rmode, input string name);
    res_t q[$];
    res_t ex;
    logic irdy, ov, co, of, z, ordy, iv, e_rdy, hold_v, cin;
    logic [31:0] sm, a, b;
    logic [1:0] op;
    logic [34:0] hold;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; hold_v = 1'b0; hold = '0;
    a = pick(); b = pick(); cin = 1'(($urandom_range(1))); op = 2'($urandom_range(3));
    while (got < n_ops && cyc < n_ops * 10 + 50) begin
      @(negedge clock);
      if (rmode == 0) ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
      else            ordy = ($urandom_range(3) != 0);
      iv = (sent < n_ops) && (rmode == 0 || $urandom_range(4) != 0);
      cyc++;
      drv(s, iv, a, b, cin, op, ordy);
      #1 smp(s, irdy, ov, sm, co, of, z);
      if (hold_v) begin
        n_vec++;
        if ({ov, sm, co, of, z} !== {1'b1, hold}) begin
          n_err++; $display("FAIL %s_stall_hold: got %b_%h_%b%b%b want 1_%h_%b",
                            name, ov, sm, co, of, z, hold[34:3], hold[2:0]);
        end
      end
      e_rdy = !(q.size() == stg_of[s] && !ordy);
      n_vec++;
      if (irdy !== e_rdy) begin
        n_err++; $display("FAIL %s_in_ready: got %b want %b (occupancy %0d)",
                          name, irdy, e_rdy, q.size());
      end
      if (ov === 1'b1 && ordy) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL %s_extra_result: got %h want none", name, sm);
        end else begin
          ex = q.pop_front();
          got++;
          if ({sm, co, of, z} !== {ex.sum, ex.cout, ex.ovf, ex.zero}) begin
            n_err++; $display("FAIL %s_result: got %h %b%b%b want %h %b%b%b", name,
                              sm, co, of, z, ex.sum, ex.cout, ex.ovf, ex.zero);
          end
        end
      end
      hold_v = (ov === 1'b1) && !ordy;
      hold   = {sm, co, of, z};
      if (iv && irdy === 1'b1) begin
        q.push_back(model(w_of[s], a, b, cin, op));
        sent++;
        a = pick(); b = pick(); cin = 1'($urandom_range(1)); op = 2'($urandom_range(3));
      end
    end
    n_vec++;
    if (got != n_ops) begin
      n_err++; $display("FAIL %s_count: got %0d results want %0d", name, got, n_ops);
    end
    drv(s, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1);
    repeat (5) begin
      @(negedge clock);
      smp(s, irdy, ov, sm, co, of, z);
      n_vec++;
      if (ov !== 1'b0) begin
        n_err++; $display("FAIL %s_drain: got out_valid %b want 0", name, ov);
      end
    end
  endtask

  task automatic test_reset();
    logic irdy, ov, co, of, z;
    logic [31:0] sm;
    reset_n = 1'b0;
    for (int s = 0; s < 4; s++) drv(s, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1);
    #2;
    for (int s = 0; s < 4; s++) begin
      smp(s, irdy, ov, sm, co, of, z);
      n_vec++;
      if ({irdy, ov, sm, co, of, z} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
        n_err++; $display("FAIL reset_state_%0d: got rdy=%b v=%b sum=%h f=%b%b%b want 1 0 0 000",
                          s, irdy, ov, sm, co, of, z);
      end
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_add_sub();
    single_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD,  32'h0000_0000, 1, 0, 1, "add_msb");
    single_op(0, 32'h0000_0000, 32'h0000_0000, 1'b1, OP_ADD,  32'h0000_0000, 0, 0, 1, "add_nocin");
    single_op(0, 32'h8000_0000, 32'h0000_0001, 1'b0, OP_SUB,  32'h7FFF_FFFF, 1, 1, 0, "sub_ovf");
    single_op(0, 32'h0000_0005, 32'h0000_0007, 1'b0, OP_SUB,  32'hFFFF_FFFE, 0, 0, 0, "sub_borrow");
    single_op(0, 32'h0000_0005, 32'h0000_0007, 1'b0, OP_SUBC, 32'hFFFF_FFFD, 0, 0, 0, "subc_cin0");
    single_op(0, 32'h0000_0003, 32'h0000_0003, 1'b0, OP_SUB,  32'h0000_0000, 1, 0, 1, "sub_equal");
    single_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD,  32'h8000_0000, 0, 1, 0, "add_ovf");
  endtask

  task automatic test_cross_group();
    int sel [3] = '{0, 2, 3};
    for (int i = 0; i < 3; i++) begin
      single_op(sel[i], 32'h00FF_FFFF, 32'h0, 1'b1, OP_ADDC, 32'h0100_0000, 0, 0, 0,
                $sformatf("addc_x%0d", stg_of[sel[i]]));
      single_op(sel[i], 32'h0000_FFFF, 32'h1, 1'b0, OP_ADD, 32'h0001_0000, 0, 0, 0,
                $sformatf("add16_x%0d", stg_of[sel[i]]));
    end
  endtask

  task automatic test_back_to_back();
    run_stream(0, 8, 0, "b2b_s2");
    run_stream(2, 8, 0, "b2b_s1");
    run_stream(3, 8, 0, "b2b_s4");
  endtask

  task automatic test_reset_mid();
    logic irdy, ov, co, of, z;
    logic [31:0] sm;
    @(negedge clock); drv(0, 1'b1, 32'h11, 32'h22, 1'b0, OP_ADD, 1'b0);
    @(negedge clock); drv(0, 1'b1, 32'h33, 32'h44, 1'b0, OP_ADD, 1'b0);
    @(negedge clock); drv(0, 1'b0, 32'h0, 32'h0, 1'b0, OP_ADD, 1'b0);
    #1 smp(0, irdy, ov, sm, co, of, z);
    n_vec++;
    if ({ov, irdy, sm} !== {1'b1, 1'b0, 32'h33}) begin
      n_err++; $display("FAIL pre_reset_full: got v=%b rdy=%b sum=%h want 1 0 00000033",
                        ov, irdy, sm);
    end
    #2 reset_n = 1'b0;
    #1 smp(0, irdy, ov, sm, co, of, z);
    n_vec++;
    if ({irdy, ov, sm, co, of, z} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
      n_err++; $display("FAIL mid_reset: got rdy=%b v=%b sum=%h f=%b%b%b want 1 0 0 000",
                        irdy, ov, sm, co, of, z);
    end
    @(negedge clock);
    reset_n = 1'b1;
    drv(0, 1'b0, 32'h0, 32'h0, 1'b0, OP_ADD, 1'b1);
    repeat (3) begin
      @(negedge clock);
      smp(0, irdy, ov, sm, co, of, z);
      n_vec++;
      if (ov !== 1'b0) begin
        n_err++; $display("FAIL post_reset_ghost: got out_valid %b want 0", ov);
      end
    end
    single_op(0, 32'h1234_0000, 32'h0000_5678, 1'b1, OP_ADD, 32'h1234_5678, 0, 0, 0,
              "post_reset");
  endtask

  task automatic test_random();
    run_stream(1, 10000, 1, "rand_w16");
    run_stream(0, 500, 1, "rand_w32");
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_cross_group();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
